// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the intersection phase controller.
//   phase_t     : the six sequencing phases plus the flashing-yellow fallback
//   LAMP_*      : one-hot lamp encodings {red,yellow,green}
//   next_phase  : successor in the normal NS -> EW rotation
//   phase_dur   : phase duration in ticks for a given set of durations
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        FLASH     = 3'd6
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // FLASH always resumes through ALLRED_B so the cross street clears first.
    function automatic phase_t next_phase(input phase_t s);
        phase_t n;
        case (s)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALLRED_A;
            ALLRED_A:  n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALLRED_B;
            ALLRED_B:  n = NS_GREEN;
            default:   n = ALLRED_B;
        endcase
        return n;
    endfunction

    function automatic int phase_dur(input phase_t s, input int green_s,
                                     input int yellow_s, input int allred_s);
        int d;
        case (s)
            NS_GREEN, EW_GREEN:   d = green_s;
            NS_YELLOW, EW_YELLOW: d = yellow_s;
            ALLRED_A, ALLRED_B:   d = allred_s;
            default:              d = 1;
        endcase
        return d;
    endfunction

    function automatic logic is_green(input phase_t s);
        return (s == NS_GREEN) || (s == EW_GREEN);
    endfunction

    function automatic logic is_allred(input phase_t s);
        return (s == ALLRED_A) || (s == ALLRED_B);
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter holding the ticks left in the current phase minus one.
//   clk, rst  : clock, synchronous active-high reset (count <= RST_VAL)
//   load      : load load_val (takes priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero
//   count     : current value
//   zero      : terminal count, count == 0
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int             W       = 5,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_phase_ctrl
// Two-road intersection phase controller advanced by a 1 s tick strobe.
//   clk, rst    : clock, synchronous active-high reset
//   tick        : one-cycle seconds strobe
//   en          : 1 = normal sequencing, 0 = flashing yellow
//   ped_req     : pedestrian request pulse (latched)
//   ns_light    : north-south lamps {red,yellow,green}
//   ew_light    : east-west lamps {red,yellow,green}
//   walk        : pedestrian walk lamp
//   remaining   : ticks left in the current phase minus one
//   phase_last  : final tick of a sequencing phase
//
// state     | meaning
// ----------+-------------------------------------------------------
// NS_GREEN  | north-south green, east-west red
// NS_YELLOW | north-south yellow, east-west red
// ALLRED_A  | both red; walk served here if requested during NS
// EW_GREEN  | east-west green, north-south red
// EW_YELLOW | east-west yellow, north-south red
// ALLRED_B  | both red; walk served here if requested during EW
// FLASH     | both yellow blinking on tick, sequencing suspended
// -----------------------------------------------------------------------------
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int pGREEN_S   = 20,
    parameter int pYELLOW_S  = 3,
    parameter int pALLRED_S  = 2,
    parameter int pPED_MIN_S = 5,
    localparam int pCNT_W    = (pGREEN_S > 1) ? $clog2(pGREEN_S) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              en,
    input  logic              ped_req,
    output logic [2:0]        ns_light,
    output logic [2:0]        ew_light,
    output logic              walk,
    output logic [pCNT_W-1:0] remaining,
    output logic              phase_last
);

    localparam logic [pCNT_W-1:0] GREEN_LOAD = pCNT_W'(pGREEN_S - 1);
    localparam logic [pCNT_W-1:0] ALLRED_LOAD = pCNT_W'(pALLRED_S - 1);
    localparam logic [pCNT_W-1:0] PED_MIN = pCNT_W'(pPED_MIN_S);

    phase_t            state, state_nxt;
    logic              ped_pend, ped_pend_nxt;
    logic              walk_phase, walk_phase_nxt;
    logic              flash_bit, flash_bit_nxt;
    logic              ped_eff;
    logic              t_load, t_dec, t_zero;
    logic [pCNT_W-1:0] t_load_val;

    phase_timer #(
        .W       (pCNT_W),
        .RST_VAL (GREEN_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_load_val),
        .dec      (t_dec),
        .count    (remaining),
        .zero     (t_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NS_GREEN;
            ped_pend   <= 1'b0;
            walk_phase <= 1'b0;
            flash_bit  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ped_pend   <= ped_pend_nxt;
            walk_phase <= walk_phase_nxt;
            flash_bit  <= flash_bit_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ped_pend_nxt   = ped_pend;
        walk_phase_nxt = walk_phase;
        flash_bit_nxt  = flash_bit;
        t_load         = 1'b0;
        t_load_val     = '0;
        t_dec          = 1'b0;
        // A request arriving this cycle counts as already pending.
        ped_eff        = ped_pend | ped_req;

        if (!en) begin
            // Disable beats any tick; the first FLASH cycle always shows yellow.
            state_nxt      = FLASH;
            t_load         = 1'b1;
            t_load_val     = '0;
            ped_pend_nxt   = 1'b0;
            walk_phase_nxt = 1'b0;
            if (state != FLASH) begin
                flash_bit_nxt = 1'b1;
            end else if (tick) begin
                flash_bit_nxt = ~flash_bit;
            end
        end else if (state == FLASH) begin
            state_nxt      = ALLRED_B;
            t_load         = 1'b1;
            t_load_val     = ALLRED_LOAD;
            walk_phase_nxt = 1'b0;
            ped_pend_nxt   = ped_req;
            flash_bit_nxt  = 1'b0;
        end else if (tick && t_zero) begin
            state_nxt  = next_phase(state);
            t_load     = 1'b1;
            t_load_val = pCNT_W'(phase_dur(state_nxt, pGREEN_S, pYELLOW_S,
                                           pALLRED_S) - 1);
            if (is_allred(state_nxt)) begin
                // The pending request is served by this all-red phase.
                walk_phase_nxt = ped_eff;
                ped_pend_nxt   = 1'b0;
            end else begin
                walk_phase_nxt = 1'b0;
                ped_pend_nxt   = ped_eff;
            end
        end else begin
            ped_pend_nxt = ped_eff;
            // Clamp takes the place of the decrement in the same cycle.
            if (is_green(state) && ped_eff && (remaining > PED_MIN)) begin
                t_load     = 1'b1;
                t_load_val = PED_MIN;
            end else begin
                t_dec = tick;
            end
        end
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state)
            NS_GREEN:  ns_light = LAMP_GRN;
            NS_YELLOW: ns_light = LAMP_YEL;
            EW_GREEN:  ew_light = LAMP_GRN;
            EW_YELLOW: ew_light = LAMP_YEL;
            FLASH: begin
                ns_light = flash_bit ? LAMP_YEL : LAMP_OFF;
                ew_light = flash_bit ? LAMP_YEL : LAMP_OFF;
            end
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign walk       = walk_phase;
    assign phase_last = t_zero && (state != FLASH);

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Two-road intersection phase controller (north-south / east-west) driven by a one-cycle seconds tick from the upstream seconds counter's expiry strobe. It sequences green, yellow and all-red phases with per-phase durations, shortens green on a latched pedestrian request, and falls back to flashing yellow when disabled. Outputs drive the lamp decoders and the remaining-seconds display directly.

## Interface
- pGREEN_S, 20, green duration in ticks (≥ pPED_MIN_S+1)
- pYELLOW_S, 3, yellow duration in ticks (≥1)
- pALLRED_S, 2, all-red duration in ticks (≥1)
- pPED_MIN_S, 5, max remaining green once a pedestrian request is pending (≥1)
- pCNT_W, $clog2(pGREEN_S), derived local width of remaining counter
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle 1 s strobe; ignored when not a single-cycle pulse is not checked
- en  in  1  1 = normal sequencing, 0 = flash mode
- ped_req  in  1  pedestrian request pulse, latched internally
- ns_light  out  3  one-hot {red,yellow,green}; all-zero only in flash-off
- ew_light  out  3  same encoding for east-west
- walk  out  1  pedestrian walk lamp
- remaining  out  pCNT_W  ticks left in current phase minus one
- phase_last  out  1  remaining==0 and not in flash

## Operation
- States: NS_GREEN → NS_YELLOW → ALLRED_A → EW_GREEN → EW_YELLOW → ALLRED_B → NS_GREEN; plus FLASH.
- Phase entry loads remaining = duration−1; each tick decrements; tick with remaining==0 transitions and loads next duration−1. Phase lasts exactly its duration in ticks.
- Lamps: green state → own green, other red; yellow state → own yellow, other red; ALLRED_x → both red; FLASH → both yellow when flash bit=1, both 000 when 0.
- Pedestrian: ped_req sets ped_pend. In a green state with ped_pend set (or ped_req this cycle) and remaining > pPED_MIN_S, remaining loads pPED_MIN_S; this overrides any decrement that cycle. Request outside green stays pending.
- ped_pend clears on entry to ALLRED_A/ALLRED_B; walk = 1 throughout that all-red phase if ped_pend was set at entry (walk_phase flag), else 0. ped_req arriving during a walk phase re-arms ped_pend for the next cycle of the sequence.
- en low in any state: next cycle enter FLASH, flash bit=1, remaining=0, walk=0, ped_pend cleared. Flash bit toggles on each tick.
- en high while in FLASH: next cycle enter ALLRED_B with remaining=pALLRED_S−1 (no walk).
- Reset: NS_GREEN, remaining=pGREEN_S−1, ns_light=001, ew_light=100, walk=0, phase_last=0 (unless pGREEN_S=1), ped_pend=0, flash bit=0. Reset wins over all inputs; mid-phase reset restarts NS_GREEN full duration.

## Timing
- State, remaining, ped_pend, walk_phase, flash bit are registers; lamps, walk, phase_last decoded combinationally from registers only (no input-to-output path).
- Tick-to-lamp change latency: 1 clk (lamps change on the edge that samples the final tick).
- en and ped_req sampled at every rising edge; effect visible 1 clk later.
- Simultaneous tick + en fall: FLASH wins; tick ignored. Tick + ped_req in green with remaining==0: transition wins (clamp irrelevant), ped_pend still set.
- Transition count per full cycle: 2·(pGREEN_S+pYELLOW_S+pALLRED_S) ticks absent requests.

## Structure
- Package traffic_pkg: phase state enum (7 values), lamp encoding constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000, and a duration lookup function state→duration.
- One sub-module: phase_timer (loadable down counter with load, load_val, dec, zero flag); FSM, ped logic and lamp decode live in the top.

## Test plan
- Reset, en=1, 60 ticks with defaults → NS_GREEN 20, NS_YELLOW 3, ALLRED_A 2, EW_GREEN 20, EW_YELLOW 3, ALLRED_B 2, back to NS_GREEN remaining=19 at tick 50.
- ped_req at NS_GREEN remaining=15 → next cycle remaining=5; yellow entered 6 ticks later; ALLRED_A has walk=1 for 2 ticks; ped_pend=0 after.
- ped_req at NS_GREEN remaining=3 → no clamp, normal countdown, walk=1 in following ALLRED_A.
- en=0 mid EW_GREEN → next clk both lamps 010, toggle 000/010 each tick; en=1 → ALLRED_B remaining=1, then NS_GREEN 20 ticks.
- rst pulse mid EW_YELLOW with tick same cycle → NS_GREEN, remaining=19, walk=0, lamps 001/100.
- tick and en=0 same cycle at remaining==0 in NS_YELLOW → FLASH, not ALLRED_A.
